fir_decimator: RTL and testbench
================================

# fir_decimator

Decimating output stage placed directly downstream of the 16-tap FIR low-pass filter. It takes the filter's Q1.15 sample stream, discards the filter's warm-up samples after reset, and keeps one sample in every R. Kept samples are buffered in a small FIFO and presented on a valid/ready interface. This lets slower consumers (file writer, UART, DAC stage) take the band-limited signal at the reduced rate.

## Interface
- N, 16: sample width, signed Q1.15 (bit N-1 sign, 15 fractional bits)
- R, 4: decimation ratio, ≥1; keep 1 of every R samples
- PHASE, 0: index within each R-group that is kept, 0..R-1
- SKIP, 18: number of valid input samples discarded after reset (covers filter pipeline fill), ≥0
- DEPTH, 8: FIFO depth, power of two, ≥2
- AW, 3: log2(DEPTH)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- data_in  in  N  signed filter output sample
- in_valid  in  1  data_in is a new sample this cycle; tie high for a free-running filter
- dec_out  out  N  signed sample at FIFO head
- out_valid  out  1  dec_out holds a valid sample
- out_ready  in  1  consumer accepts dec_out this cycle
- fifo_level  out  AW+1  number of samples stored, 0..DEPTH
- overflow  out  1  sticky flag: a kept sample was dropped because the FIFO was full
- clr_ovf  in  1  synchronous clear of overflow

## Operation
- Reset values: dec_out=0, out_valid=0, fifo_level=0, overflow=0. Warm-up counter=0, phase counter=0, FIFO pointers=0.
- Warm-up: while the warm-up count is below SKIP, each in_valid sample increments the count and is discarded. The phase counter is held at 0. With SKIP=0 there is no warm-up.
- Decimation: after warm-up, each in_valid sample is "kept" if the phase counter equals PHASE. The phase counter then increments and wraps from R-1 to 0. With in_valid=0, all counters hold.
- R=1: every post-warm-up sample is kept.
- Push: a kept sample is written to the FIFO tail if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Drop: if the FIFO is full and no pop occurs, the kept sample is dropped, the FIFO is unchanged, and overflow is set.
- Pop: occurs when out_valid && out_ready. The head advances. A pop while empty is impossible because out_valid=0.
- Simultaneous push and pop: fifo_level is unchanged and both pointers advance.
- Ordering: FIFO order is strict; samples are never reordered or duplicated.
- dec_out: driven from the registered head entry. When empty, dec_out holds its last value and out_valid=0.
- overflow: sticky until clr_ovf=1 or reset. If clr_ovf and a new drop happen in the same cycle, overflow stays 1 (set wins).
- Arithmetic: samples pass unmodified; no rounding or saturation. Counter widths are sized from R and SKIP.
- Reset mid-operation: FIFO contents are lost and warm-up restarts from 0.

## Timing
- Input sampled at rising edge k, kept, FIFO empty: out_valid=1 and dec_out=sample after edge k (1-cycle latency).
- FIFO non-empty: a new sample appears on dec_out after all earlier samples have been popped. A pop at edge j presents the next entry after edge j.
- fifo_level and overflow are registered and update at the same edge as the push, pop, or drop that causes them.
- out_valid and dec_out must not change while out_valid=1 and out_ready=0, except on reset.
- Sustained throughput: with out_ready=1, one sample per R input samples with no loss.

## Test plan
- Reset/warm-up: defaults R=4, PHASE=0, SKIP=18; data_in=1..40 with in_valid=1 and out_ready=1 → outputs 19, 23, 27, 31, 35, 39 in order, each 1 cycle after its input edge. overflow=0.
- Phase/ratio: R=3, PHASE=2, SKIP=0; inputs 0..11 → outputs 2, 5, 8, 11.
- Backpressure/overflow: R=1, SKIP=0, out_ready=0; inputs 100..109 → fifo_level saturates at 8 and overflow=1. Then out_ready=1 → exactly 100..107 pop. clr_ovf pulse → overflow=0.
- Full with simultaneous push and pop: fill to 8 with R=1, then out_ready=1 with in_valid=1 → fifo_level stays 8, overflow stays 0, order preserved.
- in_valid gaps: R=2, SKIP=2; in_valid toggling 1,0,1,0 on inputs −5..+5 → counters freeze on idle cycles. Outputs −3, −1, 1, 3, 5, with sign preserved (0xFFFD, etc.).
- Asynchronous reset mid-stream: assert reset between clock edges with the FIFO holding 3 samples → out_valid=0 and fifo_level=0 immediately. After release, the first SKIP samples are discarded again.

Source files
------------

// File: rtl/fir_decimator_if.sv
// Sample stream bundle for the decimator: filter-side input plus consumer-side valid/ready output.
// Latency: none, signal grouping only.
// Backpressure: out_ready from the consumer; the input side has no ready (filter is free-running).
interface fir_decimator_if #(
  parameter int N = 16
);
  logic signed [N-1:0] data_in;
  logic                in_valid;
  logic signed [N-1:0] dec_out;
  logic                out_valid;
  logic                out_ready;

  // Environment side: drives filter samples and consumer ready
  modport master (
    output data_in, in_valid, out_ready,
    input  dec_out, out_valid
  );

  // Decimator side
  modport slave (
    input  data_in, in_valid, out_ready,
    output dec_out, out_valid
  );
endinterface

// File: rtl/fir_decimator.sv
// Discards filter warm-up samples, keeps 1 of every R samples, buffers them in a FIFO with a valid/ready output.
// Latency: kept sample into an empty FIFO is on dec_out/out_valid one cycle after its input edge.
// Backpressure: FIFO absorbs stalls; a kept sample arriving when full without a pop is dropped and sets sticky overflow.
module fir_decimator #(
  parameter int N     = 16,
  parameter int R     = 4,
  parameter int PHASE = 0,
  parameter int SKIP  = 18,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              reset,
  fir_decimator_if.slave    bus,
  output logic [AW:0]       fifo_level,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int WCW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam int PCW = (R > 1) ? $clog2(R) : 1;

  localparam logic [WCW-1:0] WARM_LAST  = WCW'(SKIP - 1);
  localparam logic [PCW-1:0] PHASE_KEEP = PCW'(PHASE);
  localparam logic [PCW-1:0] PHASE_LAST = PCW'(R - 1);
  localparam logic [AW:0]    LVL_FULL   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]    LVL_ZERO   = '0;
  localparam logic [AW:0]    LVL_ONE    = (AW + 1)'(1);

  typedef enum logic {WARM, RUN} state_t;

  // With no warm-up requested, start directly in the decimating state
  localparam state_t INIT_STATE = (SKIP == 0) ? RUN : WARM;

  state_t              state, state_nxt;
  logic [WCW-1:0]      warm_cnt, warm_cnt_nxt;
  logic [PCW-1:0]      phase_cnt, phase_cnt_nxt;
  logic                keep;

  logic signed [N-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0]         count, count_nxt;
  logic signed [N-1:0] head_r, head_nxt;
  logic                valid_r;
  logic                full, push, pop, drop;

  // Warm-up / decimation state register and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT_STATE;
      warm_cnt  <= '0;
      phase_cnt <= '0;
    end else begin
      state     <= state_nxt;
      warm_cnt  <= warm_cnt_nxt;
      phase_cnt <= phase_cnt_nxt;
    end
  end

  // Next-state: count off warm-up samples, then select the PHASE slot of each R-group
  always_comb begin
    state_nxt     = state;
    warm_cnt_nxt  = warm_cnt;
    phase_cnt_nxt = phase_cnt;
    keep          = 1'b0;
    case (state)
      WARM: begin
        if (bus.in_valid) begin
          warm_cnt_nxt = warm_cnt + 1'b1;
          if (warm_cnt == WARM_LAST) state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          keep          = (phase_cnt == PHASE_KEEP);
          phase_cnt_nxt = (phase_cnt == PHASE_LAST) ? '0 : phase_cnt + 1'b1;
        end
      end
      default: state_nxt = INIT_STATE;
    endcase
  end

  assign full   = (count == LVL_FULL);
  assign pop    = valid_r && bus.out_ready;
  // A full FIFO still accepts a sample when the head leaves in the same cycle
  assign push   = keep && (!full || pop);
  assign drop   = keep && full && !pop;
  assign rd_nxt = rd_ptr + 1'b1;

  // Level bookkeeping and the next head value for the registered output
  always_comb begin
    count_nxt = count;
    head_nxt  = head_r;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
    if (pop && (count > LVL_ONE)) begin
      head_nxt = mem[rd_nxt];
    end else if (push && ((count == LVL_ZERO) || (pop && (count == LVL_ONE)))) begin
      // FIFO empties (or is empty) this cycle, so the arriving sample becomes the head
      head_nxt = bus.data_in;
    end
  end

  // FIFO storage; contents need no reset since pointers and level define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  // Pointers, level, registered head, and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_r   <= '0;
      valid_r  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_nxt;
      count   <= count_nxt;
      head_r  <= head_nxt;
      valid_r <= (count_nxt != LVL_ZERO);
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign bus.dec_out   = head_r;
  assign bus.out_valid = valid_r;
  assign fifo_level    = count;

endmodule

// File: tb/tb_fir_decimator.sv
// Bench for fir_decimator: four instances with different R/PHASE/SKIP, driven one at a time.
// Latency: checks registered outputs on the falling edge after each input edge.
// Backpressure: out_ready is driven per step; a queue model tracks FIFO contents and overflow.
module tb_fir_decimator;

  localparam int NI = 4;
  localparam int RS [NI] = '{4, 3, 1, 2};
  localparam int PS [NI] = '{0, 2, 0, 0};
  localparam int SS [NI] = '{18, 0, 0, 2};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] din  [NI];
  logic        vin  [NI];
  logic        rdy  [NI];
  logic        clr  [NI];
  logic [15:0] dout [NI];
  logic        vout [NI];
  logic [3:0]  lvl  [NI];
  logic        ovf  [NI];

  for (genvar g = 0; g < NI; g++) begin : u
    fir_decimator_if #(.N(16)) bus ();
    assign bus.data_in   = din[g];
    assign bus.in_valid  = vin[g];
    assign bus.out_ready = rdy[g];
    assign dout[g]       = bus.dec_out;
    assign vout[g]       = bus.out_valid;
    fir_decimator #(
      .N(16), .R(RS[g]), .PHASE(PS[g]), .SKIP(SS[g]), .DEPTH(8), .AW(3)
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .fifo_level (lvl[g]),
      .overflow   (ovf[g]),
      .clr_ovf    (clr[g])
    );
  end

  int total = 0;
  int bad   = 0;
  int cur   = 0;
  int warm, ph, movf;
  int sb  [$];
  int got [$];

  typedef struct {
    int inst;
    int first;
    int n;
    bit gap;
    int nexp;
    int exp [6];
  } case_t;
  case_t tbl [3];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int got_at(input int k);
    return (k < got.size()) ? got[k] : 32'h7fff_ffff;
  endfunction

  task automatic model_reset();
    warm = 0; ph = 0; movf = 0;
    sb.delete();
    got.delete();
  endtask

  task automatic start(input int i);
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      din[g] = '0; vin[g] = 1'b0; rdy[g] = 1'b0; clr[g] = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cur = i;
    model_reset();
  endtask

  // One input cycle on the current instance: drive, check, update model, then clock
  task automatic step(input int d, input bit v, input bit r, input bit c);
    bit full, mpop, keep;
    @(negedge clk);
    din[cur] = d[15:0]; vin[cur] = v; rdy[cur] = r; clr[cur] = c;
    chk("fifo_level", int'(lvl[cur]), sb.size());
    chk("overflow", int'(ovf[cur]), movf);
    chk("out_valid", int'(vout[cur]), int'(sb.size() != 0));
    if (vout[cur] && sb.size() != 0) chk("dec_out", $signed(dout[cur]), sb[0]);
    full = (sb.size() == 8);
    mpop = (sb.size() != 0) && r;
    if (mpop) begin
      got.push_back($signed(dout[cur]));
      void'(sb.pop_front());
    end
    keep = 1'b0;
    if (v) begin
      if (warm < SS[cur]) warm++;
      else begin
        keep = (ph == PS[cur]);
        ph = (ph == RS[cur] - 1) ? 0 : ph + 1;
      end
    end
    if (keep && (!full || mpop)) sb.push_back(d);
    if (keep && full && !mpop) movf = 1;
    else if (c) movf = 0;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 1, 40, 1'b0, 6, '{19, 23, 27, 31, 35, 39}};
    tbl[1] = '{1, 0, 12, 1'b0, 4, '{2, 5, 8, 11, 0, 0}};
    tbl[2] = '{3, -5, 11, 1'b1, 5, '{-3, -1, 1, 3, 5, 0}};

    for (int g = 0; g < NI; g++) begin
      din[g] = '0; vin[g] = 1'b0; rdy[g] = 1'b0; clr[g] = 1'b0;
    end
    reset = 1'b1;
    #12;
    for (int g = 0; g < NI; g++) begin
      chk("rst_dec_out", int'(dout[g]), 0);
      chk("rst_out_valid", int'(vout[g]), 0);
      chk("rst_level", int'(lvl[g]), 0);
      chk("rst_overflow", int'(ovf[g]), 0);
    end

    // Table scenarios: warm-up, phase/ratio, in_valid gaps with negative samples
    for (int t = 0; t < 3; t++) begin
      start(tbl[t].inst);
      for (int k = 0; k < tbl[t].n; k++) begin
        step(tbl[t].first + k, 1'b1, 1'b1, 1'b0);
        if (tbl[t].gap) step(4660, 1'b0, 1'b1, 1'b0);
      end
      repeat (4) step(0, 1'b0, 1'b1, 1'b0);
      chk("out_count", got.size(), tbl[t].nexp);
      for (int k = 0; k < tbl[t].nexp; k++) chk("out_seq", got_at(k), tbl[t].exp[k]);
      if (t == 0) begin
        #1 chk("warmup_overflow", int'(ovf[0]), 0);
      end
      if (t == 2) chk("raw_bits", got_at(0) & 32'hffff, 32'hfffd);
    end

    // Backpressure and overflow on R=1
    start(2);
    for (int k = 0; k < 10; k++) step(100 + k, 1'b1, 1'b0, 1'b0);
    #1;
    chk("bp_level", int'(lvl[2]), 8);
    chk("bp_overflow", int'(ovf[2]), 1);
    step(110, 1'b1, 1'b0, 1'b1);
    #1 chk("drop_beats_clear", int'(ovf[2]), 1);
    for (int k = 0; k < 10; k++) step(0, 1'b0, 1'b1, 1'b0);
    chk("bp_count", got.size(), 8);
    for (int k = 0; k < 8; k++) chk("bp_seq", got_at(k), 100 + k);
    step(0, 1'b0, 1'b1, 1'b1);
    #1 chk("clr_overflow", int'(ovf[2]), 0);

    // Full FIFO with simultaneous push and pop
    start(2);
    for (int k = 0; k < 8; k++) step(200 + k, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step(208 + k, 1'b1, 1'b1, 1'b0);
    #1;
    chk("full_pp_level", int'(lvl[2]), 8);
    chk("full_pp_overflow", int'(ovf[2]), 0);
    for (int k = 0; k < 10; k++) step(0, 1'b0, 1'b1, 1'b0);
    chk("full_pp_count", got.size(), 16);
    for (int k = 0; k < 16; k++) chk("full_pp_seq", got_at(k), 200 + k);

    // Asynchronous reset between edges with three samples buffered
    start(3);
    for (int k = 0; k < 8; k++) step(10 + k, 1'b1, 1'b0, 1'b0);
    #1 chk("pre_rst_level", int'(lvl[3]), 3);
    @(negedge clk);
    vin[3] = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", int'(vout[3]), 0);
    chk("async_rst_level", int'(lvl[3]), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 6; k++) step(20 + k, 1'b1, 1'b1, 1'b0);
    repeat (3) step(0, 1'b0, 1'b1, 1'b0);
    chk("rst_rewarm_count", got.size(), 2);
    chk("rst_rewarm_0", got_at(0), 22);
    chk("rst_rewarm_1", got_at(1), 24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
